canny_hysteresis_track: RTL and testbench

//  Final Canny stage, directly downstream of non-maximum suppression. Takes the 2-bit
//  per-pixel edge class stream and applies single-pass double-threshold hysteresis.
//  A pixel is kept when it is strong, or when it is weak and touches a strong pixel.

---
 rtl/canny_hysteresis_track.sv | 188 ++++++++++++++++++
 tb/tb_canny_hysteresis_track.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/canny_hysteresis_track.sv
// Canny hysteresis stage: single-pass double-threshold edge tracking over the NMS class
// stream, producing a binary edge map, a display pixel and a per-frame edge count.
module canny_hysteresis_track #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned CNT_WIDTH  = 20
) (
   input  logic                 clk,
   input  logic                 rst_s,
   input  logic                 per_frame_vsync,
   input  logic                 per_frame_href,
   input  logic                 per_frame_clken,
   input  logic [1:0]           per_class,
   output logic                 post_frame_vsync,
   output logic                 post_frame_href,
   output logic                 post_frame_clken,
   output logic                 post_edge,
   output logic [7:0]           post_img_y,
   output logic [CNT_WIDTH-1:0] frame_edge_cnt,
   output logic                 frame_cnt_valid
);
   localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int unsigned ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

   typedef enum logic {S_WAIT_SYNC, S_RUN} state_t;

   state_t           state_q, state_n;
   logic             armed;
   logic             t1_vsync, t1_href, t1_clken;
   logic [COL_W-1:0] col_q;
   logic             col_ovf;
   logic [ROW_W-1:0] row_q;
   logic [1:0]       line_a [IMG_WIDTH];
   logic [1:0]       line_b [IMG_WIDTH];
   // Window: strong flags per column (bit 0 = row r-2, bit 2 = row r) plus the centre class.
   logic [2:0]       str_l, str_c;
   logic [1:0]       ctr_cls;
   logic             s1_keep;
   logic             post_vsync_d;
   logic             in_frame;
   logic [CNT_WIDTH-1:0] edge_cnt;

   logic             vs_rise_c, hs_rise_c, hs_fall_c, sync_now_c, beat_c, wr_c;
   logic [COL_W-1:0] cur_col_c;
   logic             cur_ovf_c;
   logic [ROW_W-1:0] cur_row_c;
   logic [1:0]       rd_a_c, rd_b_c;
   logic [2:0]       col_str_c, live_str_c;
   logic             keep_c, nb_strong_c;
   logic             post_rise_c, post_fall_c, count_beat_c;
   logic             unused_rd_b_lsb;

   // Input edge detection and current beat position.
   assign vs_rise_c  = armed & per_frame_vsync & ~t1_vsync;
   assign hs_rise_c  = per_frame_href & ~t1_href;
   assign hs_fall_c  = ~per_frame_href & t1_href;
   assign cur_col_c  = hs_rise_c ? '0 : col_q;
   assign cur_ovf_c  = hs_rise_c ? 1'b0 : col_ovf;
   assign cur_row_c  = vs_rise_c ? '0 : row_q;
   assign beat_c     = per_frame_clken & ~cur_ovf_c;
   assign wr_c       = beat_c & sync_now_c;

   assign rd_a_c          = line_a[cur_col_c];
   assign rd_b_c          = line_b[cur_col_c];
   assign unused_rd_b_lsb = rd_b_c[0];
   assign col_str_c       = {per_class[1], rd_a_c[1], rd_b_c[1]};
   // The incoming beat is the right-hand window column; nothing to the right of a line end.
   assign live_str_c      = (per_frame_clken & ~hs_rise_c) ? col_str_c : 3'b000;

   assign nb_strong_c = (|str_l) | str_c[0] | str_c[2] | (|live_str_c);
   assign keep_c      = s1_keep & (ctr_cls[1] | ((ctr_cls == 2'b01) & nb_strong_c));

   assign post_rise_c  = post_frame_vsync & ~post_vsync_d;
   assign post_fall_c  = ~post_frame_vsync & post_vsync_d;
   assign count_beat_c = post_frame_clken & post_edge;

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) state_q <= S_WAIT_SYNC;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n    = state_q;
      sync_now_c = 1'b0;
      case (state_q)
         S_WAIT_SYNC: begin
            sync_now_c = vs_rise_c;
            if (vs_rise_c) state_n = S_RUN;
         end
         S_RUN: sync_now_c = 1'b1;
         default: state_n = S_WAIT_SYNC;
      endcase
   end

   // Line buffers, read-before-write at the column address.
   always_ff @(posedge clk) begin
      if (wr_c) begin
         line_a[cur_col_c] <= per_class;
         line_b[cur_col_c] <= rd_a_c;
      end
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         armed    <= 1'b0;
         t1_vsync <= 1'b0;
         t1_href  <= 1'b0;
         t1_clken <= 1'b0;
         col_q    <= '0;
         col_ovf  <= 1'b0;
         row_q    <= '0;
         str_l    <= '0;
         str_c    <= '0;
         ctr_cls  <= '0;
         s1_keep  <= 1'b0;
      end else begin
         armed    <= 1'b1;
         t1_vsync <= per_frame_vsync;
         t1_href  <= per_frame_href;
         t1_clken <= per_frame_clken;
         if (per_frame_clken) begin
            if (cur_col_c == COL_LAST) begin
               col_q   <= cur_col_c;
               col_ovf <= 1'b1;
            end else begin
               col_q   <= cur_col_c + COL_W'(1);
               col_ovf <= cur_ovf_c;
            end
            str_l   <= str_c;
            str_c   <= col_str_c;
            ctr_cls <= rd_a_c;
         end else begin
            col_q   <= cur_col_c;
            col_ovf <= cur_ovf_c;
         end
         if (vs_rise_c)                            row_q <= '0;
         else if (hs_fall_c && row_q != ROW_LAST)  row_q <= row_q + ROW_W'(1);
         s1_keep <= wr_c & (cur_row_c >= ROW_FIRST) & (cur_col_c != '0) &
                    (cur_col_c != COL_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         post_frame_vsync <= 1'b0;
         post_frame_href  <= 1'b0;
         post_frame_clken <= 1'b0;
         post_edge        <= 1'b0;
         post_img_y       <= '0;
      end else begin
         post_frame_vsync <= t1_vsync;
         post_frame_href  <= t1_href;
         post_frame_clken <= t1_clken;
         post_edge        <= keep_c;
         post_img_y       <= {8{keep_c}};
      end
   end

   // Frame edge count, framed by the output-side vsync so in-flight beats are included.
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         post_vsync_d    <= 1'b0;
         in_frame        <= 1'b0;
         edge_cnt        <= '0;
         frame_edge_cnt  <= '0;
         frame_cnt_valid <= 1'b0;
      end else begin
         post_vsync_d    <= post_frame_vsync;
         frame_cnt_valid <= 1'b0;
         if (post_rise_c) begin
            edge_cnt <= CNT_WIDTH'(count_beat_c);
            in_frame <= (state_q == S_RUN);
         end else if (post_fall_c) begin
            if (in_frame) begin
               frame_edge_cnt  <= edge_cnt;
               frame_cnt_valid <= 1'b1;
            end
            edge_cnt <= '0;
            in_frame <= 1'b0;
         end else if (count_beat_c && (edge_cnt != '1)) begin
            edge_cnt <= edge_cnt + CNT_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_canny_hysteresis_track.sv
// Directed bench for canny_hysteresis_track on an 8x6 image with a 2-clk scoreboard.
module tb_canny_hysteresis_track;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int CW = 20;

   logic          clk = 1'b0;
   logic          rst_s;
   logic          per_frame_vsync, per_frame_href, per_frame_clken;
   logic [1:0]    per_class;
   logic          post_frame_vsync, post_frame_href, post_frame_clken, post_edge;
   logic [7:0]    post_img_y;
   logic [CW-1:0] frame_edge_cnt;
   logic          frame_cnt_valid;

   typedef struct packed {
      logic vs;
      logic hs;
      logic ck;
      logic chk;
      logic ex;
   } exp_t;

   exp_t       sbq[$];
   logic [1:0] img [H][W];
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;

   canny_hysteresis_track #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_s(rst_s),
      .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
      .per_frame_clken(per_frame_clken), .per_class(per_class),
      .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
      .post_frame_clken(post_frame_clken), .post_edge(post_edge), .post_img_y(post_img_y),
      .frame_edge_cnt(frame_edge_cnt), .frame_cnt_valid(frame_cnt_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_cnt_valid) pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference decision for image pixel (r-1,k), emitted on input beat (r,k).
   function automatic logic exp_edge(input int r, input int k);
      int   i;
      logic nb;
      i = r - 1;
      if (i < 1 || i > H - 2 || k < 1 || k > W - 2) return 1'b0;
      if (img[i][k][1]) return 1'b1;
      if (img[i][k] != 2'b01) return 1'b0;
      nb = 1'b0;
      for (int di = -1; di <= 1; di++)
         for (int dj = -1; dj <= 1; dj++)
            if (di != 0 || dj != 0) nb |= img[i+di][k+dj][1];
      return nb;
   endfunction

   task automatic fill(input logic [1:0] cls);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = cls;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_vsync"}, 32'(post_frame_vsync), 32'd0);
      check({tag, "_href"},  32'(post_frame_href),  32'd0);
      check({tag, "_clken"}, 32'(post_frame_clken), 32'd0);
      check({tag, "_edge"},  32'(post_edge),        32'd0);
      check({tag, "_img_y"}, 32'(post_img_y),       32'd0);
      check({tag, "_cnt"},   32'(frame_edge_cnt),   32'd0);
      check({tag, "_valid"}, 32'(frame_cnt_valid),  32'd0);
   endtask

   // One clock of stimulus; the entry pushed two ticks earlier is popped and compared.
   task automatic tick(input logic vs, input logic hs, input logic ck, input logic [1:0] cls,
                       input logic chk, input logic ex);
      exp_t e;
      per_frame_vsync = vs;
      per_frame_href  = hs;
      per_frame_clken = ck;
      per_class       = cls;
      e.vs = vs; e.hs = hs; e.ck = ck; e.chk = chk; e.ex = ex;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (sbq.size() == 2) begin
         e = sbq.pop_front();
         check("post_vsync", 32'(post_frame_vsync), 32'(e.vs));
         check("post_href",  32'(post_frame_href),  32'(e.hs));
         check("post_clken", 32'(post_frame_clken), 32'(e.ck));
         if (e.chk) begin
            check("post_edge",  32'(post_edge),  32'(e.ex));
            check("post_img_y", 32'(post_img_y), 32'({8{e.ex}}));
         end
      end
   endtask

   task automatic run_frame(input int len, input int rst_row, output int sum);
      logic       live;
      logic [1:0] cls;
      logic       ex;
      live = 1'b1;
      sum  = 0;
      repeat (2) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      repeat (2) tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      for (int r = 0; r < H; r++) begin
         for (int k = 0; k < len; k++) begin
            if (r == rst_row && k == 3) begin
               rst_s = 1'b0;
               #1;
               check_zero("midrst");
               @(negedge clk);
               @(negedge clk);
               rst_s = 1'b1;
               sbq.delete();
               live = 1'b0;
            end
            cls = (k < W) ? img[r][k] : 2'b10;
            ex  = live & exp_edge(r, k);
            if (ex) sum++;
            tick(1'b1, 1'b1, 1'b1, cls, 1'b1, ex);
         end
         repeat (3) tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      end
      repeat (6) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
   endtask

   initial begin
      int   sum;
      int   p0;
      logic vs, hs;
      rst_s = 1'b0;
      per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
      per_class = 2'b00;
      @(negedge clk);
      @(negedge clk);
      check_zero("reset");
      rst_s = 1'b1;

      // Strong lines before any vsync rising edge must not produce edges.
      repeat (3) begin
         repeat (W) tick(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
         repeat (2) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      end

      fill(2'b10);
      p0 = pulses;
      run_frame(W, -1, sum);
      check("strong_pulses", 32'(pulses), 32'(p0 + 1));
      check("strong_cnt", 32'(frame_edge_cnt), 32'd24);

      fill(2'b01);
      img[2][3] = 2'b10;
      p0 = pulses;
      run_frame(W, -1, sum);
      check("single_pulses", 32'(pulses), 32'(p0 + 1));
      check("single_cnt", 32'(frame_edge_cnt), 32'd9);

      fill(2'b00);
      img[2][1] = 2'b10;
      img[2][2] = 2'b01; img[2][3] = 2'b01; img[2][4] = 2'b01;
      p0 = pulses;
      run_frame(W, -1, sum);
      check("chain_pulses", 32'(pulses), 32'(p0 + 1));
      check("chain_cnt", 32'(frame_edge_cnt), 32'd2);

      // Random sync pattern: only the 2-clk timing alignment is compared.
      vs = 1'b0;
      for (int t = 0; t < 120; t++) begin
         if ($urandom_range(0, 7) == 0) vs = ~vs;
         hs = ($urandom_range(0, 2) != 0);
         tick(vs, hs, hs, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      end
      repeat (8) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

      fill(2'b10);
      p0 = pulses;
      run_frame(W, 3, sum);
      check("rst_frame_pulses", 32'(pulses), 32'(p0));
      p0 = pulses;
      run_frame(W, -1, sum);
      check("after_rst_pulses", 32'(pulses), 32'(p0 + 1));
      check("after_rst_cnt", 32'(frame_edge_cnt), 32'd24);

      fill(2'b01);
      img[2][3] = 2'b10;
      p0 = pulses;
      run_frame(W + 2, -1, sum);
      check("overlong_pulses", 32'(pulses), 32'(p0 + 1));
      check("overlong_cnt", 32'(frame_edge_cnt), 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
